axi_lite_ch_src: RTL

- Source (initiator) end of a single AXI-lite channel (AW, W or AR).
- Local logic pushes payload words into a small FIFO. The block presents them on the channel as valid/data and retires each word on a valid&&ready handshake.
- Pairs with the existing channel receiver.
- Obeys AXI rules:
  - valid never depends on ready.
  - data is held stable while valid && !ready.

---
 rtl/axi_lite_ch_src.sv | 103 ++++++++++
 1 files changed

// File: rtl/axi_lite_ch_src.sv
// rtl/axi_lite_ch_src.sv - AXI-lite channel source: push FIFO presented as valid/data with handshake retire
// Optional stall watchdog enabled by defining AXI_LITE_CH_SRC_TIMEOUT_EN.
module axi_lite_ch_src #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid,
    input  logic                     ready,
    output logic [DATA_W-1:0]        data,
    output logic                     xfer,
    output logic                     ovf,
    output logic                     stall_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_ovf;
    logic              w_push_ok;
    logic              w_pop;

    // valid and data decode registered state only, so neither can depend on ready
    assign valid     = (r_count != '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign xfer      = valid && ready;
    assign data      = valid ? r_mem[r_rd_ptr] : '0;
    assign ovf       = r_ovf;
    assign w_push_ok = push && !full;
    assign w_pop     = xfer;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            // full is judged before the pop, so a push into a full FIFO is lost even on a handshake
            if (push && full) begin
                r_ovf <= 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef AXI_LITE_CH_SRC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

    logic [TW-1:0] r_stall_cnt;
    logic          r_stall_err;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else if (valid && !ready) begin
            if (r_stall_cnt != T_MAX) begin
                r_stall_cnt <= r_stall_cnt + TW'(1);
            end
            // flag at the same edge the counter reaches TIMEOUT
            if (r_stall_cnt == T_MAX - TW'(1)) begin
                r_stall_err <= 1'b1;
            end
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign stall_err = r_stall_err;
`else
    assign stall_err = 1'b0;
`endif

endmodule
